// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, FSM states, instruction classes and IR field positions for the Mini SRC control unit
// No ports; imported by instr_class_decode and alu_sequencer.
package cpu_ctrl_pkg;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT, S_FAULT
    } state_e;

    typedef enum logic [3:0] {
        CL_RALU, CL_IALU, CL_UNARY, CL_MULDIV, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILLEGAL
    } iclass_e;
endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: maps a 5-bit opcode to its instruction class
// Ports: opcode (in, 5) -> iclass (out, iclass_e); purely combinational.
module instr_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_e    iclass
);
    always_comb
        iclass = (opcode >= OP_ADD && opcode <= OP_SHL)   ? CL_RALU   :
                 (opcode >= OP_ADDI && opcode <= OP_ORI)  ? CL_IALU   :
                 (opcode == OP_NEG || opcode == OP_NOT)   ? CL_UNARY  :
                 (opcode == OP_DIV || opcode == OP_MUL)   ? CL_MULDIV :
                 (opcode == OP_MFHI)                      ? CL_MFHI   :
                 (opcode == OP_MFLO)                      ? CL_MFLO   :
                 (opcode == OP_NOP)                       ? CL_NOP    :
                 (opcode == OP_HALT)                      ? CL_HALT   : CL_ILLEGAL;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: hardwired fetch/execute control unit driving the Mini SRC datapath strobes
// Ports: clk, clr (async active-low), start pulse, IR, mem_ready in;
// fetch, execute and register-select strobes, ALU_opcode, run and illegal out.
module alu_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin,
    output logic        Yin, Cout, ZLOout, ZHIout, HIin, LOin, HIout, LOout,
    output logic        Gra, Grb, Grc, Rin, Rout,
    output logic [4:0]  ALU_opcode,
    output logic        run,
    output logic        illegal
);
    localparam int WW = $clog2(MEM_WAIT_MAX + 1);

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    iclass_e       cls;
    logic [4:0]    opcode;
    logic          unused_ir;
    logic          ralu, ialu, unary, muldiv, mfhi, mflo, first_t1;

    assign opcode    = IR[OPC_MSB:OPC_LSB];
    assign unused_ir = ^IR[OPC_LSB-1:0];

    instr_class_decode u_dec (.opcode(opcode), .iclass(cls));

    assign ralu     = cls == CL_RALU;
    assign ialu     = cls == CL_IALU;
    assign unary    = cls == CL_UNARY;
    assign muldiv   = cls == CL_MULDIV;
    assign mfhi     = cls == CL_MFHI;
    assign mflo     = cls == CL_MFLO;
    // The counter is zero only on the first T1 cycle, so it doubles as the PC-strobe gate.
    assign first_t1 = wait_q == '0;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_T0 : S_IDLE;
            S_T0:    state_d = S_T1;
            S_T1: begin
                // mem_ready is tested first so it wins on the cycle the timeout would fire.
                state_d = mem_ready ? S_T2 :
                          (wait_q == WW'(MEM_WAIT_MAX - 1)) ? S_FAULT : S_T1;
                wait_d  = mem_ready ? '0 : wait_q + 1'b1;
            end
            S_T2:    state_d = (cls == CL_HALT) ? S_HALT :
                               (cls == CL_NOP || cls == CL_ILLEGAL) ? S_T0 : S_T3;
            S_T3:    state_d = (mfhi || mflo) ? S_T0 : S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = muldiv ? S_T6 : S_T0;
            S_T6:    state_d = S_T0;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin,
         Yin, Cout, ZLOout, ZHIout, HIin, LOin, HIout, LOout,
         Gra, Grb, Grc, Rin, Rout, run, illegal} = 24'b0;
        ALU_opcode = 5'b0;
        run = !(state_q inside {S_IDLE, S_HALT, S_FAULT});
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                ZLOout = first_t1;
                PCin   = first_t1;
                Read   = 1'b1;
                MDRin  = 1'b1;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                illegal = cls == CL_ILLEGAL;
            end
            S_T3: begin
                Grb   = ralu | ialu;
                Gra   = muldiv | mfhi | mflo;
                Rout  = ralu | ialu | muldiv;
                Yin   = ralu | ialu | muldiv;
                HIout = mfhi;
                LOout = mflo;
                Rin   = mfhi | mflo;
            end
            S_T4: begin
                ALU_opcode = opcode;
                Grc  = ralu;
                Grb  = unary | muldiv;
                Rout = ralu | unary | muldiv;
                Cout = ialu;
                Zin  = 1'b1;
            end
            S_T5: begin
                ZLOout = 1'b1;
                Gra    = !muldiv;
                Rin    = !muldiv;
                LOin   = muldiv;
            end
            S_T6: begin
                ZHIout = 1'b1;
                HIin   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven per-cycle strobe checks plus wait/fault/halt/reset corner sequences
module tb_alu_sequencer;
    logic        clk = 1'b0, clr = 1'b1, start = 1'b0, mem_ready = 1'b0;
    logic [31:0] IR = '0;
    logic PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin;
    logic Yin, Cout, ZLOout, ZHIout, HIin, LOin, HIout, LOout;
    logic Gra, Grb, Grc, Rin, Rout, run, illegal;
    logic [4:0]  ALU_opcode;
    logic [23:0] obs;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .clr(clr), .start(start), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Cout(Cout), .ZLOout(ZLOout),
        .ZHIout(ZHIout), .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .ALU_opcode(ALU_opcode), .run(run), .illegal(illegal)
    );

    assign obs = {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin,
                  Yin, Cout, ZLOout, ZHIout, HIin, LOin, HIout, LOout,
                  Gra, Grb, Grc, Rin, Rout, run, illegal};

    localparam logic [23:0] PCO = 24'd1 << 23, MAR = 24'd1 << 22, INC = 24'd1 << 21, ZIN = 24'd1 << 20;
    localparam logic [23:0] PCI = 24'd1 << 19, RD  = 24'd1 << 18, MDI = 24'd1 << 17, MDO = 24'd1 << 16;
    localparam logic [23:0] IRI = 24'd1 << 15, YIN = 24'd1 << 14, CO  = 24'd1 << 13, ZLO = 24'd1 << 12;
    localparam logic [23:0] ZHI = 24'd1 << 11, HII = 24'd1 << 10, LOI = 24'd1 << 9,  HIO = 24'd1 << 8;
    localparam logic [23:0] LOO = 24'd1 << 7,  GRA = 24'd1 << 6,  GRB = 24'd1 << 5,  GRC = 24'd1 << 4;
    localparam logic [23:0] RIN = 24'd1 << 3,  ROU = 24'd1 << 2,  RUN = 24'd1 << 1,  ILL = 24'd1;
    localparam logic [23:0] T0S = PCO | MAR | INC | ZIN | RUN;
    localparam logic [23:0] T1S = ZLO | PCI | RD | MDI | RUN;
    localparam logic [23:0] T1W = RD | MDI | RUN;
    localparam logic [23:0] T2S = MDO | IRI | RUN;
    localparam logic [23:0] WBK = ZLO | GRA | RIN | RUN;

    localparam logic [31:0] I_NOT = 32'h90080000, I_ADD = 32'h19890000, I_ADDI = 32'h60000000;
    localparam logic [31:0] I_MUL = 32'h81A00000, I_MFHI = 32'hC0000000, I_MFLO = 32'hC8000000;
    localparam logic [31:0] I_NOP = 32'hD0000000, I_HALT = 32'hD8000000, I_BAD = 32'hF8000000;

    typedef struct {
        logic [31:0] ir;
        logic        mr;
        logic [23:0] e;
        logic [4:0]  a;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [31:0] ir, input logic mr, input logic [23:0] e, input logic [4:0] a);
        vec_t v;
        v.ir = ir;
        v.mr = mr;
        v.e  = e;
        v.a  = a;
        tbl.push_back(v);
    endtask

    task automatic fetch(input logic [31:0] ir);
        add(ir, 1'b1, T0S, 5'b0);
        add(ir, 1'b1, T1S, 5'b0);
        add(ir, 1'b1, T2S, 5'b0);
    endtask

    task automatic chk(input string name, input logic [23:0] e, input logic [4:0] a);
        checks++;
        if (obs !== e || ALU_opcode !== a) begin
            errors++;
            $display("FAIL %s: strobes=%06h alu=%05b, required strobes=%06h alu=%05b", name, obs, ALU_opcode, e, a);
        end
    endtask

    task automatic cyc(input logic [31:0] ir, input logic mr, input logic [23:0] e, input logic [4:0] a, input string name);
        IR = ir;
        mem_ready = mr;
        @(negedge clk);
        chk(name, e, a);
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [31:0] ir);
        @(negedge clk);
        IR = ir;
        clr = 1'b0;
        #1;
        chk("clr_async_zero", 24'b0, 5'b0);
        @(negedge clk);
        clr = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 clr = 1'b0;
        IR = I_ADD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_idle", 24'b0, 5'b0);
        start = 1'b1;
        @(negedge clk);
        chk("reset_holds_against_start", 24'b0, 5'b0);

        fetch(I_NOT);
        add(I_NOT, 1'b1, RUN, 5'b0);
        add(I_NOT, 1'b1, GRB | ROU | ZIN | RUN, 5'b10010);
        add(I_NOT, 1'b1, WBK, 5'b0);
        fetch(I_ADD);
        add(I_ADD, 1'b1, GRB | ROU | YIN | RUN, 5'b0);
        add(I_ADD, 1'b1, GRC | ROU | ZIN | RUN, 5'b00011);
        add(I_ADD, 1'b1, WBK, 5'b0);
        fetch(I_ADDI);
        add(I_ADDI, 1'b1, GRB | ROU | YIN | RUN, 5'b0);
        add(I_ADDI, 1'b1, CO | ZIN | RUN, 5'b01100);
        add(I_ADDI, 1'b1, WBK, 5'b0);
        fetch(I_MUL);
        add(I_MUL, 1'b1, GRA | ROU | YIN | RUN, 5'b0);
        add(I_MUL, 1'b1, GRB | ROU | ZIN | RUN, 5'b10000);
        add(I_MUL, 1'b1, ZLO | LOI | RUN, 5'b0);
        add(I_MUL, 1'b1, ZHI | HII | RUN, 5'b0);
        fetch(I_MFHI);
        add(I_MFHI, 1'b1, HIO | GRA | RIN | RUN, 5'b0);
        fetch(I_MFLO);
        add(I_MFLO, 1'b1, LOO | GRA | RIN | RUN, 5'b0);
        fetch(I_NOP);
        add(I_ADD, 1'b0, T0S, 5'b0);
        add(I_ADD, 1'b0, T1S, 5'b0);
        add(I_ADD, 1'b0, T1W, 5'b0);
        add(I_ADD, 1'b0, T1W, 5'b0);
        add(I_ADD, 1'b1, T1W, 5'b0);
        add(I_ADD, 1'b1, T2S, 5'b0);
        add(I_ADD, 1'b1, GRB | ROU | YIN | RUN, 5'b0);
        add(I_ADD, 1'b1, GRC | ROU | ZIN | RUN, 5'b00011);
        add(I_ADD, 1'b1, WBK, 5'b0);
        add(I_BAD, 1'b1, T0S, 5'b0);
        add(I_BAD, 1'b1, T1S, 5'b0);
        add(I_BAD, 1'b1, T2S | ILL, 5'b0);
        fetch(I_HALT);
        add(I_HALT, 1'b1, 24'b0, 5'b0);
        add(I_HALT, 1'b1, 24'b0, 5'b0);

        clr = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        foreach (tbl[i]) cyc(tbl[i].ir, tbl[i].mr, tbl[i].e, tbl[i].a, $sformatf("vec%0d", i));

        start = 1'b1;
        cyc(I_ADD, 1'b1, 24'b0, 5'b0, "halt_start_ignored");
        start = 1'b0;
        cyc(I_ADD, 1'b1, 24'b0, 5'b0, "halt_stays");

        restart(I_ADD);
        cyc(I_ADD, 1'b0, T0S, 5'b0, "fault_t0");
        cyc(I_ADD, 1'b0, T1S, 5'b0, "fault_t1_first");
        for (int k = 2; k <= 15; k++) cyc(I_ADD, 1'b0, T1W, 5'b0, $sformatf("fault_t1_wait%0d", k));
        start = 1'b1;
        cyc(I_ADD, 1'b1, 24'b0, 5'b0, "fault_entered");
        start = 1'b0;
        cyc(I_ADD, 1'b1, 24'b0, 5'b0, "fault_stays");

        restart(I_ADD);
        cyc(I_ADD, 1'b0, T0S, 5'b0, "edge_t0");
        cyc(I_ADD, 1'b0, T1S, 5'b0, "edge_t1_first");
        for (int k = 2; k <= 14; k++) cyc(I_ADD, 1'b0, T1W, 5'b0, $sformatf("edge_t1_wait%0d", k));
        cyc(I_ADD, 1'b1, T1W, 5'b0, "edge_t1_ready_at_limit");
        cyc(I_ADD, 1'b1, T2S, 5'b0, "edge_ready_wins_t2");

        restart(I_ADD);
        cyc(I_ADD, 1'b1, T0S, 5'b0, "clr_t0");
        cyc(I_ADD, 1'b1, T1S, 5'b0, "clr_t1");
        cyc(I_ADD, 1'b1, T2S, 5'b0, "clr_t2");
        cyc(I_ADD, 1'b1, GRB | ROU | YIN | RUN, 5'b0, "clr_t3");
        @(negedge clk);
        chk("clr_t4_before", GRC | ROU | ZIN | RUN, 5'b00011);
        #2 clr = 1'b0;
        #1 chk("clr_mid_t4_async", 24'b0, 5'b0);
        @(posedge clk);
        #1 clr = 1'b1;
        cyc(I_ADD, 1'b1, 24'b0, 5'b0, "idle_after_clr");
        cyc(I_ADD, 1'b1, 24'b0, 5'b0, "idle_waits_start");
        start = 1'b1;
        cyc(I_ADD, 1'b1, 24'b0, 5'b0, "idle_start_seen");
        start = 1'b0;
        cyc(I_ADD, 1'b1, T0S, 5'b0, "restart_t0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
